// File: rtl/tick_pkg.sv
// Shared types and helpers for the tick timer bank: channel FSM states,
// channel run modes and the prescaler divide-ratio calculation.
package tick_pkg;

  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

  typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} ch_mode_t;

  // Divide ratio from system clock to base tick; 0 flags an unusable tick rate.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) begin
      return 0;
    end
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick prescaler: a $clog2(DIV)-bit counter wrapping 0..DIV-1 whose
// terminal count is decoded into a one-cycle base_tick. pause holds the count.
module tick_prescaler
  import tick_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BASE_TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic pause,
  output logic base_tick
);

  localparam int DIV   = calc_div(CLK_HZ, BASE_TICK_HZ);
  localparam int PSC_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PSC_W-1:0] LAST = PSC_W'(DIV - 1);

  if ((DIV < 2) || ((CLK_HZ % BASE_TICK_HZ) != 0)) begin : g_bad_div
    $error("tick_prescaler: CLK_HZ/BASE_TICK_HZ must be an integer >= 2");
  end

  logic [PSC_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (!pause) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

  // Holding the count while paused means release resumes with no lost tick.
  assign base_tick = w_at_last && !pause;

endmodule

// File: rtl/tick_timer_bank.sv
// Bank of N_CH independent countdown timers clocked by a shared base tick.
// Optional build macro TICK_BANK_PAUSE_EN adds a pause input that freezes
// the prescaler (and hence every channel) while start/stop stay live.
module tick_timer_bank
  import tick_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BASE_TICK_HZ = 1000,
  parameter int N_CH         = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef TICK_BANK_PAUSE_EN
  input  logic                  pause,
`endif
  output logic                  base_tick,
  input  logic [N_CH-1:0]       ch_start,
  input  logic [N_CH-1:0]       ch_stop,
  input  logic [N_CH-1:0]       ch_mode,
  input  logic [N_CH*CNT_W-1:0] ch_period,
  output logic [N_CH-1:0]       ch_tick,
  output logic [N_CH-1:0]       ch_busy,
  output logic [N_CH*CNT_W-1:0] ch_remaining
);

  if ((N_CH < 1) || (N_CH > 16)) begin : g_bad_nch
    $error("tick_timer_bank: N_CH must be in 1..16");
  end

  logic w_pause;
  logic w_base_tick;

`ifdef TICK_BANK_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  tick_prescaler #(
    .CLK_HZ       (CLK_HZ),
    .BASE_TICK_HZ (BASE_TICK_HZ)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .pause     (w_pause),
    .base_tick (w_base_tick)
  );

  assign base_tick = w_base_tick;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_state_t        r_state, w_state_nxt;
    ch_mode_t         r_mode, w_mode_nxt;
    logic [CNT_W-1:0] r_reload, w_reload_nxt;
    logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
    logic             r_tick, w_tick_nxt;
    logic [CNT_W-1:0] w_period;
    logic             w_busy;
    logic [CNT_W-1:0] w_rem_out;

    assign w_period = ch_period[g*CNT_W +: CNT_W];

    // State register.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state     <= CH_IDLE;
        r_mode      <= MODE_PERIODIC;
        r_reload    <= '0;
        r_remaining <= '0;
        r_tick      <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_mode      <= w_mode_nxt;
        r_reload    <= w_reload_nxt;
        r_remaining <= w_remaining_nxt;
        r_tick      <= w_tick_nxt;
      end
    end

    // Next-state: stop beats start, start beats a coincident base tick.
    always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      w_state_nxt     = r_state;
      w_mode_nxt      = r_mode;
      w_reload_nxt    = r_reload;
      w_remaining_nxt = r_remaining;
      w_tick_nxt      = 1'b0;

      if (ch_stop[g]) begin
        w_state_nxt     = CH_IDLE;
        w_remaining_nxt = '0;
      end else if (ch_start[g]) begin
        if (w_period != '0) begin
          w_state_nxt     = CH_RUN;
          w_mode_nxt      = ch_mode_t'(ch_mode[g]);
          w_reload_nxt    = w_period;
          w_remaining_nxt = w_period;
        end else begin
          w_state_nxt     = CH_IDLE;
          w_remaining_nxt = '0;
        end
      end else if ((r_state == CH_RUN) && w_base_tick) begin
        if (r_remaining == CNT_W'(1)) begin
          w_tick_nxt = 1'b1;
          if (r_mode == MODE_ONESHOT) begin
            w_state_nxt     = CH_IDLE;
            w_remaining_nxt = '0;
          end else begin
            w_remaining_nxt = r_reload;
          end
        end else begin
          w_remaining_nxt = r_remaining - 1'b1;
        end
      end
    end

    // Outputs.
    always_comb begin
      w_busy    = (r_state == CH_RUN);
      w_rem_out = w_busy ? r_remaining : '0;
    end

    assign ch_tick[g]                      = r_tick;
    assign ch_busy[g]                      = w_busy;
    assign ch_remaining[g*CNT_W +: CNT_W]  = w_rem_out;
  end

endmodule

// File: tb/tb_tick_timer_bank.sv
// Directed bench for tick_timer_bank with DIV=10, four 8-bit channels.
// Pause scenario is compiled in only when TICK_BANK_PAUSE_EN is defined.
module tb_tick_timer_bank;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic                  clk;
  logic                  rst;
  logic                  pause;
  logic                  base_tick;
  logic [N_CH-1:0]       ch_start;
  logic [N_CH-1:0]       ch_stop;
  logic [N_CH-1:0]       ch_mode;
  logic [N_CH*CNT_W-1:0] ch_period;
  logic [N_CH-1:0]       ch_tick;
  logic [N_CH-1:0]       ch_busy;
  logic [N_CH*CNT_W-1:0] ch_remaining;

  int errors;
  int checks;
  int t;
  int tick_cnt[N_CH];

  tick_timer_bank #(
    .CLK_HZ       (1000),
    .BASE_TICK_HZ (100),
    .N_CH         (N_CH),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef TICK_BANK_PAUSE_EN
    .pause        (pause),
`endif
    .base_tick    (base_tick),
    .ch_start     (ch_start),
    .ch_stop      (ch_stop),
    .ch_mode      (ch_mode),
    .ch_period    (ch_period),
    .ch_tick      (ch_tick),
    .ch_busy      (ch_busy),
    .ch_remaining (ch_remaining)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // One clock: sample #1 after the rising edge and tally expiry pulses.
  task automatic step1();
    @(posedge clk);
    #1;
    t++;
    for (int i = 0; i < N_CH; i++) begin
      tick_cnt[i] += int'(ch_tick[i]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) step1();
  endtask

  task automatic step_to(input int target);
    while (t < target) step1();
  endtask

  task automatic set_ch(input int idx, input logic mode, input logic [CNT_W-1:0] period);
    ch_mode[idx]                  = mode;
    ch_period[idx*CNT_W +: CNT_W] = period;
  endtask

  function automatic logic [31:0] rem(input int idx);
    return 32'(ch_remaining[idx*CNT_W +: CNT_W]);
  endfunction

  initial begin
    errors    = 0;
    checks    = 0;
    t         = 0;
    rst       = 1'b1;
    pause     = 1'b0;
    ch_start  = '0;
    ch_stop   = '0;
    ch_mode   = '0;
    ch_period = '0;
    for (int i = 0; i < N_CH; i++) tick_cnt[i] = 0;

    // Reset state.
    step(3);
    check("rst_base_tick", 32'(base_tick), 32'd0);
    check("rst_busy", 32'(ch_busy), 32'd0);
    check("rst_tick", 32'(ch_tick), 32'd0);
    check("rst_remaining", 32'(ch_remaining), 32'd0);

    // Release: now in cycle 1 (count 0). First pulse in cycle 10, then 20, 30.
    rst = 1'b0;
    step(8);
    check("bt_cycle9", 32'(base_tick), 32'd0);
    step(1);
    check("bt_cycle10", 32'(base_tick), 32'd1);
    step(1);
    check("bt_cycle11", 32'(base_tick), 32'd0);
    step(9);
    check("bt_cycle20", 32'(base_tick), 32'd1);
    step(10);
    check("bt_cycle30", 32'(base_tick), 32'd1);

    // Mid-count reset in cycle 33: count returns to 0, next pulse 10 cycles on.
    step(3);
    rst = 1'b1;
    step(1);
    check("bt_in_rst", 32'(base_tick), 32'd0);
    rst = 1'b0;
    step(8);
    check("bt_after_rst_c9", 32'(base_tick), 32'd0);
    step(1);
    check("bt_after_rst_c10", 32'(base_tick), 32'd1);
    step(1);

    // Channel phase: t=0 is a cycle with prescaler count 0; base ticks at t%10==9.
    t = 0;
    for (int i = 0; i < N_CH; i++) tick_cnt[i] = 0;
    set_ch(0, 1'b0, 8'd3);
    set_ch(1, 1'b1, 8'd2);
    set_ch(2, 1'b0, 8'd0);
    set_ch(3, 1'b0, 8'd7);
    ch_start = 4'b1111;
    ch_stop  = 4'b1000;
    step_to(1);
    ch_start = '0;
    ch_stop  = '0;
    check("busy_after_start", 32'(ch_busy), 32'b0011);
    check("rem0_load", rem(0), 32'd3);
    check("rem1_load", rem(1), 32'd2);
    check("rem2_period0", rem(2), 32'd0);
    check("rem3_startstop", rem(3), 32'd0);
    step_to(9);
    check("rem0_before_bt1", rem(0), 32'd3);
    step_to(10);
    check("rem0_after_bt1", rem(0), 32'd2);
    check("rem1_after_bt1", rem(1), 32'd1);
    step_to(19);
    check("tick_before_bt2", 32'(ch_tick), 32'd0);
    step_to(20);
    check("ch1_oneshot_tick", 32'(ch_tick), 32'b0010);
    check("busy_after_oneshot", 32'(ch_busy), 32'b0001);
    check("rem1_after_oneshot", rem(1), 32'd0);
    check("rem0_at_20", rem(0), 32'd1);
    step_to(21);
    check("tick_one_cycle", 32'(ch_tick), 32'd0);
    step_to(30);
    check("ch0_tick_30", 32'(ch_tick), 32'b0001);
    check("rem0_reload", rem(0), 32'd3);
    check("busy0_periodic", 32'(ch_busy[0]), 32'd1);
    step_to(60);
    check("ch0_tick_60", 32'(ch_tick), 32'b0001);
    step_to(90);
    check("ch0_tick_90", 32'(ch_tick), 32'b0001);

    // Stop coincident with expiry: no pulse.
    step_to(119);
    check("rem0_at_119", rem(0), 32'd1);
    check("bt_at_119", 32'(base_tick), 32'd1);
    ch_stop[0] = 1'b1;
    step_to(120);
    ch_stop = '0;
    check("stop_vs_expiry_tick", 32'(ch_tick), 32'd0);
    check("stop_busy", 32'(ch_busy), 32'd0);
    check("stop_rem0", rem(0), 32'd0);
    step_to(140);
    check("cnt_ch0", 32'(tick_cnt[0]), 32'd3);
    check("cnt_ch1", 32'(tick_cnt[1]), 32'd1);
    check("cnt_ch2", 32'(tick_cnt[2]), 32'd0);
    check("cnt_ch3", 32'(tick_cnt[3]), 32'd0);

    // Restart ch0 with period 5 while remaining=1 and base_tick coincide.
    set_ch(0, 1'b0, 8'd3);
    ch_start[0] = 1'b1;
    step_to(141);
    ch_start = '0;
    step_to(169);
    check("rem0_pre_restart", rem(0), 32'd1);
    set_ch(0, 1'b0, 8'd5);
    ch_start[0] = 1'b1;
    step_to(170);
    ch_start = '0;
    check("restart_no_tick", 32'(ch_tick), 32'd0);
    check("restart_rem0", rem(0), 32'd5);
    check("restart_busy0", 32'(ch_busy[0]), 32'd1);
    step_to(219);
    check("restart_rem0_219", rem(0), 32'd1);
    check("restart_cnt_ch0", 32'(tick_cnt[0]), 32'd3);
    step_to(220);
    check("restart_tick_220", 32'(ch_tick), 32'b0001);
    check("restart_rem0_reload", rem(0), 32'd5);

    // Periodic P=1 on ch2: one pulse per base tick.
    set_ch(2, 1'b0, 8'd1);
    ch_start[2] = 1'b1;
    step_to(221);
    ch_start = '0;
    check("p1_rem2", rem(2), 32'd1);
    step_to(230);
    check("p1_tick_230", 32'(ch_tick[2]), 32'd1);
    step_to(231);
    check("p1_tick_231", 32'(ch_tick[2]), 32'd0);
    step_to(240);
    check("p1_tick_240", 32'(ch_tick[2]), 32'd1);

`ifdef TICK_BANK_PAUSE_EN
    // Pause for 25 cycles starting on a would-be base-tick cycle.
    step_to(249);
    pause = 1'b1;
    #1;
    check("pause_bt_forced0", 32'(base_tick), 32'd0);
    check("pause_rem0_249", rem(0), 32'd3);
    step_to(260);
    check("pause_bt_260", 32'(base_tick), 32'd0);
    check("pause_rem0_frozen", rem(0), 32'd3);
    step_to(274);
    pause = 1'b0;
    #1;
    check("resume_bt_274", 32'(base_tick), 32'd1);
    step_to(275);
    check("resume_rem0_275", rem(0), 32'd2);
    step_to(283);
    check("resume_bt_283", 32'(base_tick), 32'd0);
    step_to(284);
    check("resume_bt_284", 32'(base_tick), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
